peak_window_detect: RTL and testbench
=====================================

# peak_window_detect

Parametrised multi-channel windowed peak detector for the DDC output path. Tracks the running maximum of NCH sample streams over a programmable window of clock cycles. At each window boundary it publishes every channel's peak plus the overall peak and its channel index, then restarts. Generalises the fixed 1 ms, single-channel, unsigned peak hold with a shared input valid, signed/unsigned compare, a configurable window and an empty-window indication.

## Interface

Parameters:
- DATA_W, 32, sample width per channel.
- NCH, 4, channel count (≥1); IDX_W = max(1, clog2(NCH)).
- WIN_W, 24, width of window length.
- WIN_DEFAULT, 150000, window length loaded at reset (1 ms at 150 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies data_in this cycle, shared by all channels.
- data_in  in  NCH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- win_len  in  WIN_W  window length in clk cycles; sampled at window start.
- signed_mode  in  1  1 = two's-complement compare; sampled at window start.
- max_out  out  NCH*DATA_W  per-channel peak of the last completed window.
- max_valid  out  1  one-cycle pulse when max_out updates.
- win_empty  out  1  last completed window had no in_valid cycles; updates with max_out.
- all_max  out  DATA_W  largest of max_out.
- all_idx  out  IDX_W  channel holding all_max.
- all_valid  out  1  one-cycle pulse when all_max/all_idx update.

## Operation

- Window counter wcnt runs 0..L-1, where L = the latched win_len. Values 0 or 1 are clamped to L = 2.
- Cycle with wcnt == L-1 is the terminal cycle T. At the next edge wcnt returns to 0, and win_len and signed_mode are re-latched.
- Floor value: 0 in unsigned mode; most-negative value (1 followed by DATA_W-1 zeros) in signed mode.
- Running max run[c] starts each window at the floor.
- Each cycle with in_valid: run[c] <= data_in[c] if data_in[c] > run[c] under the latched compare mode.
- At T, the published value is max(run[c], the cycle-T sample if valid). The result goes to max_out[c], max_valid pulses, and run[c] reloads to the floor.
- A T-cycle sample belongs to the closing window, never the new one.
- win_empty = 1 if no in_valid occurred during the window. max_out then equals the floor.
- Reduction stage: registered compare across max_out under the compare mode of the window just closed.
  - Ties resolve to the lowest channel index.
  - Result goes to all_max/all_idx with an all_valid pulse.
- Changes to win_len or signed_mode mid-window have no effect until the next window start.

## Timing

- Reset values:
  - max_out = 0, all_max = 0, all_idx = 0.
  - max_valid = 0, all_valid = 0, win_empty = 1.
  - wcnt = 0, run = 0, latched L = WIN_DEFAULT, latched signed_mode = 0.
- First window after reset runs WIN_DEFAULT cycles, counted from the first cycle with rst low.
- max_valid is high during cycle T+1.
- all_valid is high during cycle T+2.
- Pulse period is exactly L cycles.
- Reset asserted mid-window discards the partial window; nothing is published.
- Reset asserted in cycle T or T+1 suppresses the pending max_valid and all_valid.
- Back-to-back windows never lose a sample: the cycle after T accumulates into the new window.
- Throughput: one sample per channel per clock, no stall.

## Configuration

- PEAK_MIN_EN defined: adds a minimum tracker alongside the maximum tracker.
  - Extra output ports min_out (NCH*DATA_W) and all_min (DATA_W).
  - Running-min floor is all-ones (unsigned) or the most-positive value (signed).
  - min_out updates with max_valid; all_min updates with all_valid.
  - Empty window reports the floor.
- PEAK_MIN_EN not defined: ports and logic are absent; behaviour is otherwise identical.

## Test plan

- Unsigned basic:
  - Stimulus: NCH=4, win_len=8, in_valid=1; channel c ramps c*10+k for k=0..7.
  - Response: max_out = {37,27,17,7} one cycle after the 8th sample; all_max=37, all_idx=3 one cycle later.
- Signed mode:
  - Stimulus: signed_mode=1; channel 0 gets only -5, -2, -9.
  - Response: max_out[0] = -2 (0xFFFFFFFE). The same data with signed_mode=0 gives 0xFFFFFFFE as well; a mixed window {-1, 3} gives 3 (signed) vs 0xFFFFFFFF (unsigned).
- Terminal-cycle and boundary sample:
  - Stimulus: a peak of 100 arrives exactly at cycle T; 50 arrives at T+1.
  - Response: the 100 is reported in the closing window; the next window reports 50.
- Empty window, tie, and clamp:
  - Stimulus: in_valid=0 for a whole window.
  - Response: win_empty=1, max_out all 0.
  - Stimulus: equal peaks on channels 1 and 2.
  - Response: all_idx=1.
  - Stimulus: win_len=0.
  - Response: max_valid period is 2 cycles.
- Mid-window changes:
  - Stimulus: rst pulse at wcnt=3.
  - Response: no max_valid; outputs return to reset values; the next window is WIN_DEFAULT long.
  - Stimulus: win_len changed from 8 to 4 mid-window.
  - Response: the current window still ends at 8 cycles.
- PEAK_MIN_EN:
  - Stimulus: channel 0 samples {9, 3, 7}, unsigned.
  - Response: min_out[0] = 3 and max_out[0] = 9 on the same max_valid.

Source files
------------

// File: rtl/peak_window_detect.sv
// Multi-channel windowed peak detector: per-channel running max, published at each
// window boundary, plus a registered overall max/index stage. `define PEAK_MIN_EN adds min tracking.
module peak_window_detect #(
    parameter int DATA_W      = 32,
    parameter int NCH         = 4,
    parameter int WIN_W       = 24,
    parameter int WIN_DEFAULT = 150000,
    localparam int IDX_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [NCH*DATA_W-1:0] data_in,
    input  logic [WIN_W-1:0]      win_len,
    input  logic                  signed_mode,
`ifdef PEAK_MIN_EN
    output logic [NCH*DATA_W-1:0] min_out,
    output logic [DATA_W-1:0]     all_min,
`endif
    output logic [NCH*DATA_W-1:0] max_out,
    output logic                  max_valid,
    output logic                  win_empty,
    output logic [DATA_W-1:0]     all_max,
    output logic [IDX_W-1:0]      all_idx,
    output logic                  all_valid
);

    typedef logic [DATA_W-1:0] sample_t;

    function automatic logic gt(input sample_t a, input sample_t b, input logic sm);
        return sm ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic sample_t max_floor(input logic sm);
        return sm ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    endfunction

    function automatic logic [WIN_W-1:0] clamp_len(input logic [WIN_W-1:0] l);
        return (l < WIN_W'(2)) ? WIN_W'(2) : l;
    endfunction

    logic [WIN_W-1:0] wcnt_q, wcnt_d, len_q, len_d;
    logic             smode_q, smode_d, red_mode_q, red_mode_d;
    logic             seen_q, seen_d;
    logic             term;
    sample_t          samp   [NCH];
    sample_t          acc    [NCH];
    sample_t          run_q  [NCH], run_d [NCH];
    sample_t          max_q  [NCH], max_d [NCH];
    logic             max_valid_q, max_valid_d, win_empty_q, win_empty_d;
    sample_t          all_max_q, all_max_d, best;
    logic [IDX_W-1:0] all_idx_q, all_idx_d, best_idx;
    logic             all_valid_q, all_valid_d;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        term        = (wcnt_q == len_q - WIN_W'(1));
        wcnt_d      = term ? '0 : wcnt_q + WIN_W'(1);
        len_d       = term ? clamp_len(win_len) : len_q;
        smode_d     = term ? signed_mode : smode_q;
        seen_d      = term ? 1'b0 : (seen_q | in_valid);
        max_valid_d = term;
        win_empty_d = win_empty_q;
        red_mode_d  = red_mode_q;
        if (term) begin
            win_empty_d = ~(seen_q | in_valid);
            red_mode_d  = smode_q;
        end
        for (int c = 0; c < NCH; c++) begin
            samp[c]  = data_in[c*DATA_W +: DATA_W];
            // The terminal-cycle sample is folded into the closing window's result.
            acc[c]   = (in_valid && gt(samp[c], run_q[c], smode_q)) ? samp[c] : run_q[c];
            max_d[c] = term ? acc[c] : max_q[c];
            run_d[c] = term ? max_floor(signed_mode) : acc[c];
        end
    end

    // Reduction uses the compare mode of the window that just closed; strict compare keeps ties low.
    always_comb begin
        best     = max_q[0];
        best_idx = '0;
        for (int c = 1; c < NCH; c++) begin
            if (gt(max_q[c], best, red_mode_q)) begin
                best     = max_q[c];
                best_idx = IDX_W'(c);
            end
        end
        all_valid_d = max_valid_q;
        all_max_d   = max_valid_q ? best : all_max_q;
        all_idx_d   = max_valid_q ? best_idx : all_idx_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            len_q       <= clamp_len(WIN_W'(WIN_DEFAULT));
            smode_q     <= 1'b0;
            red_mode_q  <= 1'b0;
            seen_q      <= 1'b0;
            max_valid_q <= 1'b0;
            win_empty_q <= 1'b1;
            all_max_q   <= '0;
            all_idx_q   <= '0;
            all_valid_q <= 1'b0;
            // NOTE: these small per-channel arrays are flops, not RAM, and must read as defined values after reset.
            for (int c = 0; c < NCH; c++) begin
                run_q[c] <= '0;
                max_q[c] <= '0;
            end
        end else begin
            wcnt_q      <= wcnt_d;
            len_q       <= len_d;
            smode_q     <= smode_d;
            red_mode_q  <= red_mode_d;
            seen_q      <= seen_d;
            max_valid_q <= max_valid_d;
            win_empty_q <= win_empty_d;
            all_max_q   <= all_max_d;
            all_idx_q   <= all_idx_d;
            all_valid_q <= all_valid_d;
            for (int c = 0; c < NCH; c++) begin
                run_q[c] <= run_d[c];
                max_q[c] <= max_d[c];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_max_out
        assign max_out[c*DATA_W +: DATA_W] = max_q[c];
    end

    assign max_valid = max_valid_q;
    assign win_empty = win_empty_q;
    assign all_max   = all_max_q;
    assign all_idx   = all_idx_q;
    assign all_valid = all_valid_q;

`ifdef PEAK_MIN_EN
    function automatic sample_t min_floor(input logic sm);
        return sm ? {1'b0, {(DATA_W-1){1'b1}}} : '1;
    endfunction

    sample_t minacc    [NCH];
    sample_t min_run_q [NCH], min_run_d [NCH];
    sample_t min_q     [NCH], min_d     [NCH];
    sample_t all_min_q, all_min_d, least;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            minacc[c]    = (in_valid && gt(min_run_q[c], samp[c], smode_q)) ? samp[c] : min_run_q[c];
            min_d[c]     = term ? minacc[c] : min_q[c];
            min_run_d[c] = term ? min_floor(signed_mode) : minacc[c];
        end
        least = min_q[0];
        for (int c = 1; c < NCH; c++) begin
            if (gt(least, min_q[c], red_mode_q)) least = min_q[c];
        end
        all_min_d = max_valid_q ? least : all_min_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            all_min_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                min_run_q[c] <= '1;
                min_q[c]     <= '0;
            end
        end else begin
            all_min_q <= all_min_d;
            for (int c = 0; c < NCH; c++) begin
                min_run_q[c] <= min_run_d[c];
                min_q[c]     <= min_d[c];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_min_out
        assign min_out[c*DATA_W +: DATA_W] = min_q[c];
    end
    assign all_min = all_min_q;
`endif

endmodule

// File: tb/tb_peak_window_detect.sv
// Randomized self-checking bench for peak_window_detect with a window-level reference model
// (samples of each window are collected, then reduced when the window closes).
module tb_peak_window_detect;
    localparam int DATA_W      = 32;
    localparam int NCH         = 4;
    localparam int WIN_W       = 8;
    localparam int WIN_DEFAULT = 20;
    localparam int IDX_W       = 2;

    typedef logic [DATA_W-1:0]     sample_t;
    typedef logic [NCH*DATA_W-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst, in_valid, signed_mode;
    vec_t             data_in;
    logic [WIN_W-1:0] win_len;
    vec_t             max_out;
    logic             max_valid, win_empty, all_valid;
    sample_t          all_max;
    logic [IDX_W-1:0] all_idx;
`ifdef PEAK_MIN_EN
    vec_t             min_out;
    sample_t          all_min;
`endif

    always #5 clk = ~clk;

    peak_window_detect #(
        .DATA_W(DATA_W), .NCH(NCH), .WIN_W(WIN_W), .WIN_DEFAULT(WIN_DEFAULT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .win_len(win_len), .signed_mode(signed_mode),
`ifdef PEAK_MIN_EN
        .min_out(min_out), .all_min(all_min),
`endif
        .max_out(max_out), .max_valid(max_valid), .win_empty(win_empty),
        .all_max(all_max), .all_idx(all_idx), .all_valid(all_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mv_pulses = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int unsigned m_len, m_pos;
    logic        m_mode;
    vec_t        hist[$];
    sample_t     e_max [NCH];
    logic        e_empty, e_mv, e_av;
    sample_t     e_all_max, p_all_max;
    int          e_all_idx, p_all_idx;
`ifdef PEAK_MIN_EN
    sample_t     e_min [NCH];
    sample_t     e_all_min, p_all_min;
`endif

    function automatic longint val(input sample_t x, input logic sm);
        return sm ? longint'($signed(x)) : longint'(x);
    endfunction

    task automatic model_reset();
        m_len = WIN_DEFAULT; m_pos = 0; m_mode = 1'b0;
        hist.delete();
        for (int c = 0; c < NCH; c++) e_max[c] = '0;
        e_empty = 1'b1; e_mv = 1'b0; e_av = 1'b0;
        e_all_max = '0; e_all_idx = 0; p_all_max = '0; p_all_idx = 0;
`ifdef PEAK_MIN_EN
        for (int c = 0; c < NCH; c++) e_min[c] = '0;
        e_all_min = '0; p_all_min = '0;
`endif
    endtask

    task automatic close_window();
        vec_t    row;
        sample_t s, best, fl;
        longint  top;
        bit      found;
        fl = m_mode ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
        e_empty = (hist.size() == 0);
        for (int c = 0; c < NCH; c++) begin
            best = fl;
            foreach (hist[i]) begin
                row = hist[i];
                s = row[c*DATA_W +: DATA_W];
                if (val(s, m_mode) > val(best, m_mode)) best = s;
            end
            e_max[c] = best;
        end
        top = val(e_max[0], m_mode);
        for (int c = 1; c < NCH; c++) if (val(e_max[c], m_mode) > top) top = val(e_max[c], m_mode);
        found = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!found && val(e_max[c], m_mode) == top) begin
                found = 1'b1; p_all_idx = c; p_all_max = e_max[c];
            end
        end
`ifdef PEAK_MIN_EN
        fl = m_mode ? {1'b0, {(DATA_W-1){1'b1}}} : '1;
        for (int c = 0; c < NCH; c++) begin
            best = fl;
            foreach (hist[i]) begin
                row = hist[i];
                s = row[c*DATA_W +: DATA_W];
                if (val(s, m_mode) < val(best, m_mode)) best = s;
            end
            e_min[c] = best;
        end
        p_all_min = e_min[0];
        for (int c = 1; c < NCH; c++) if (val(e_min[c], m_mode) < val(p_all_min, m_mode)) p_all_min = e_min[c];
`endif
    endtask

    task automatic check_outputs();
        if (max_valid === 1'b1) mv_pulses++;
        check("max_valid", 64'(max_valid), 64'(e_mv));
        check("all_valid", 64'(all_valid), 64'(e_av));
        check("win_empty", 64'(win_empty), 64'(e_empty));
        check("all_max", 64'(all_max), 64'(e_all_max));
        check("all_idx", 64'(all_idx), 64'(e_all_idx));
        for (int c = 0; c < NCH; c++)
            check($sformatf("max_out[%0d]", c), 64'(max_out[c*DATA_W +: DATA_W]), 64'(e_max[c]));
`ifdef PEAK_MIN_EN
        check("all_min", 64'(all_min), 64'(e_all_min));
        for (int c = 0; c < NCH; c++)
            check($sformatf("min_out[%0d]", c), 64'(min_out[c*DATA_W +: DATA_W]), 64'(e_min[c]));
`endif
    endtask

    // One clock: check outputs mid-cycle, drive inputs, advance the model.
    task automatic cycle(input logic r, input logic v, input vec_t d, input logic [WIN_W-1:0] wl, input logic sm);
        @(negedge clk);
        if (chk_en) check_outputs();
        rst = r; in_valid = v; data_in = d; win_len = wl; signed_mode = sm;
        if (r) begin
            model_reset();
        end else begin
            if (e_mv) begin
                e_all_max = p_all_max; e_all_idx = p_all_idx;
`ifdef PEAK_MIN_EN
                e_all_min = p_all_min;
`endif
            end
            e_av = e_mv;
            if (v) hist.push_back(d);
            m_pos++;
            if (m_pos == m_len) begin
                close_window();
                m_len  = (wl < 2) ? 2 : int'(wl);
                m_mode = sm;
                m_pos  = 0;
                hist.delete();
                e_mv = 1'b1;
            end else begin
                e_mv = 1'b0;
            end
        end
        chk_en = 1'b1;
    endtask

    function automatic vec_t rnd_data();
        vec_t        d;
        sample_t     pick [4];
        int unsigned kind;
        pick = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        kind = $urandom_range(0, 3);
        for (int c = 0; c < NCH; c++) begin
            case (kind)
                0:       d[c*DATA_W +: DATA_W] = sample_t'($urandom_range(0, 7));
                2:       d[c*DATA_W +: DATA_W] = pick[$urandom_range(0, 3)];
                default: d[c*DATA_W +: DATA_W] = sample_t'($urandom);
            endcase
        end
        return d;
    endfunction

    function automatic vec_t pack4(input sample_t a, input sample_t b, input sample_t c, input sample_t d);
        return {d, c, b, a};
    endfunction

    // Run random traffic until a window closes with the requested length/mode latched.
    task automatic align(input logic [WIN_W-1:0] wl, input logic sm);
        do cycle(1'b0, 1'($urandom_range(0, 1)), rnd_data(), wl, sm);
        while (m_pos != 0);
    endtask

    task automatic ch0_window(input logic sm, input sample_t a, input sample_t b, input sample_t c,
                              input int n, input string tag, input sample_t exp);
        sample_t v [3];
        vec_t    d;
        v = '{a, b, c};
        align(8, sm);
        for (int k = 0; k < 8; k++) begin
            d = rnd_data();
            d[DATA_W-1:0] = v[k % 3];
            cycle(1'b0, 1'(k < n), d, 8, sm);
        end
        cycle(1'b0, 1'b0, rnd_data(), 8, sm);
        check(tag, 64'(max_out[DATA_W-1:0]), 64'(exp));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = '0; win_len = 8; signed_mode = 1'b0;
        model_reset();
        repeat (3) cycle(1'b1, 1'b0, '0, 8, 1'b0);

        // Reset values, then the first window runs WIN_DEFAULT cycles
        mv_pulses = 0;
        repeat (WIN_DEFAULT) cycle(1'b0, 1'($urandom_range(0, 1)), rnd_data(), 8, 1'b0);
        check("rst_all_max", 64'(all_max), 64'(0));
        check("first_win_no_pulse", 64'(mv_pulses), 64'(0));
        cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("first_win_pulse", 64'(mv_pulses), 64'(1));

        // Unsigned ramp
        align(8, 1'b0);
        for (int k = 0; k < 8; k++)
            cycle(1'b0, 1'b1, pack4(sample_t'(k), sample_t'(10 + k), sample_t'(20 + k), sample_t'(30 + k)), 8, 1'b0);
        cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        for (int c = 0; c < NCH; c++)
            check($sformatf("ramp_max[%0d]", c), 64'(max_out[c*DATA_W +: DATA_W]), 64'(c * 10 + 7));
        cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("ramp_all_max", 64'(all_max), 64'(37));
        check("ramp_all_idx", 64'(all_idx), 64'(3));

        // Signed versus unsigned compare
        ch0_window(1'b1, sample_t'(-5), sample_t'(-2), sample_t'(-9), 3, "signed_neg", 32'hFFFF_FFFE);
        ch0_window(1'b0, sample_t'(-5), sample_t'(-2), sample_t'(-9), 3, "unsigned_neg", 32'hFFFF_FFFE);
        ch0_window(1'b1, sample_t'(-1), sample_t'(3), sample_t'(3), 2, "signed_mixed", 32'd3);
        ch0_window(1'b0, sample_t'(-1), sample_t'(3), sample_t'(3), 2, "unsigned_mixed", 32'hFFFF_FFFF);

        // Terminal-cycle sample stays in the closing window; T+1 sample opens the next
        align(8, 1'b0);
        repeat (7) cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        cycle(1'b0, 1'b1, pack4(100, 1, 1, 1), 8, 1'b0);
        cycle(1'b0, 1'b1, pack4(50, 2, 2, 2), 8, 1'b0);
        check("boundary_T", 64'(max_out[DATA_W-1:0]), 64'(100));
        repeat (7) cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("boundary_T1", 64'(max_out[DATA_W-1:0]), 64'(50));

        // Empty window
        align(8, 1'b0);
        repeat (9) cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("empty_flag", 64'(win_empty), 64'(1));
        check("empty_max0", 64'(max_out[DATA_W-1:0]), 64'(0));

        // Tie between channels 1 and 2
        align(8, 1'b0);
        for (int k = 0; k < 8; k++)
            cycle(1'b0, 1'b1, (k == 4) ? pack4(10, 500, 500, 20) : pack4(1, 2, 3, 4), 8, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("tie_idx", 64'(all_idx), 64'(1));
        check("tie_max", 64'(all_max), 64'(500));

        // win_len = 0 clamps to a period of 2
        align(0, 1'b0);
        mv_pulses = 0;
        repeat (10) cycle(1'b0, 1'b1, rnd_data(), 0, 1'b0);
        check("clamp_period", 64'(mv_pulses), 64'(5));

        // Reset at wcnt = 3 discards the window; next window is WIN_DEFAULT long
        align(8, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, rnd_data(), 8, 1'b0);
        cycle(1'b1, 1'b1, rnd_data(), 8, 1'b0);
        mv_pulses = 0;
        repeat (WIN_DEFAULT) cycle(1'b0, 1'b1, rnd_data(), 8, 1'b0);
        check("midrst_no_pulse", 64'(mv_pulses), 64'(0));
        cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("midrst_pulse", 64'(mv_pulses), 64'(1));

        // Reset in the terminal cycle suppresses the pending pulses
        align(4, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, rnd_data(), 4, 1'b0);
        cycle(1'b1, 1'b1, rnd_data(), 4, 1'b0);
        cycle(1'b0, 1'b0, rnd_data(), 4, 1'b0);
        check("rst_T_no_pulse", 64'(max_valid), 64'(0));

        // win_len change mid-window takes effect only at the next window
        align(8, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, rnd_data(), 8, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, rnd_data(), 4, 1'b0);
        cycle(1'b0, 1'b0, rnd_data(), 4, 1'b0);
        check("len_change_T", 64'(max_valid), 64'(1));

`ifdef PEAK_MIN_EN
        align(8, 1'b0);
        for (int k = 0; k < 8; k++)
            cycle(1'b0, 1'(k < 3), pack4((k == 0) ? 9 : (k == 1) ? 3 : 7, 5, 5, 5), 8, 1'b0);
        cycle(1'b0, 1'b0, rnd_data(), 8, 1'b0);
        check("min_ch0", 64'(min_out[DATA_W-1:0]), 64'(3));
        check("min_max_ch0", 64'(max_out[DATA_W-1:0]), 64'(9));
`endif

        // Random traffic: lengths, modes and valids change every cycle
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0), rnd_data(),
                  WIN_W'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        cycle(1'b0, 1'b0, '0, 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
